alu_addsub_acc: RTL and testbench

Parametrised, registered signed adder/subtractor with accumulate mode, selectable saturation, a per-result overflow flag and a sticky overflow flag. It is the next-generation arithmetic slice of the ALU. Operands enter through a valid/ready handshake, and one result leaves per accepted operation through a backpressurable output register. In accumulate mode, results chain through an internal accumulator.

---
 rtl/alu_addsub_acc.sv | 74 +++++++
 tb/tb_alu_addsub_acc.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_addsub_acc.sv
// alu_addsub_acc: registered signed add/sub/accumulate slice with saturation, overflow and sticky flags
module alu_addsub_acc #(
   parameter int LEN = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic signed [LEN-1:0] i_a,
   input  logic signed [LEN-1:0] i_b,
   input  logic        [1:0]     i_mode,
   input  logic                  i_sat,
   input  logic                  i_clr_flags,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic signed [LEN-1:0] o_sum,
   output logic                  o_carry,
   output logic                  o_ovf_sticky,
   output logic signed [LEN-1:0] o_acc
);
   localparam logic [1:0] MODE_SUB = 2'b01;
   localparam logic [1:0] MODE_LOAD = 2'b11;
   localparam logic signed [LEN-1:0] SAT_MAX = {1'b0, {(LEN-1){1'b1}}};
   localparam logic signed [LEN-1:0] SAT_MIN = {1'b1, {(LEN-1){1'b0}}};
   logic                  valid_q, valid_d;
   logic signed [LEN-1:0] sum_q, sum_d;
   logic                  carry_q, carry_d;
   logic                  sticky_q, sticky_d;
   logic signed [LEN-1:0] acc_q, acc_d;
   logic                  accept;
   logic signed [LEN:0]   ext_l, ext_r, res_x;
   logic                  ovf;
   logic signed [LEN-1:0] res;
   assign o_ready      = !valid_q || i_ready;
   assign accept       = i_valid && o_ready;
   assign o_valid      = valid_q;
   assign o_sum        = sum_q;
   assign o_carry      = carry_q;
   assign o_ovf_sticky = sticky_q;
   assign o_acc        = acc_q;
   // exact LEN+1 bit result, overflow detection and wrap/saturate selection
   always_comb begin
      ext_l = i_mode[1] ? {acc_q[LEN-1], acc_q} : {i_a[LEN-1], i_a};
      ext_r = i_mode[1] ? {i_a[LEN-1], i_a} : {i_b[LEN-1], i_b};
      res_x = (i_mode == MODE_SUB) ? ext_l - ext_r : ext_l + ext_r;
      ovf   = (i_mode != MODE_LOAD) && (res_x[LEN] != res_x[LEN-1]);
      res   = (i_mode == MODE_LOAD) ? i_a :
              (ovf && i_sat) ? (res_x[LEN] ? SAT_MIN : SAT_MAX) : res_x[LEN-1:0];
   end
   // next state: capture on accept, drain when downstream takes the result, set beats clear on sticky
   always_comb begin
      valid_d  = accept || (valid_q && !i_ready);
      sum_d    = accept ? res : sum_q;
      carry_d  = accept ? ovf : carry_q;
      acc_d    = (accept && i_mode[1]) ? res : acc_q;
      sticky_d = (accept && ovf) || (sticky_q && !i_clr_flags);
   end
   // state registers with asynchronous reset dropping any in-flight result
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q  <= 1'b0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         sticky_q <= 1'b0;
         acc_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         sticky_q <= sticky_d;
         acc_q    <= acc_d;
      end
   end
endmodule

// File: tb/tb_alu_addsub_acc.sv
// tb_alu_addsub_acc: directed test-plan cases plus random traffic against an integer reference model
module tb_alu_addsub_acc;
   localparam int L = 4;
   localparam int MAXV = (1 << (L-1)) - 1;
   localparam int MINV = -(1 << (L-1));
   logic clk = 1'b0;
   logic rst, i_valid, o_ready, i_sat, i_clr_flags, o_valid, i_ready, o_carry, o_ovf_sticky;
   logic signed [L-1:0] i_a, i_b, o_sum, o_acc;
   logic [1:0] i_mode;
   int total = 0, bad = 0;
   int m_valid = 0, m_sum = 0, m_carry = 0, m_sticky = 0, m_acc = 0;

   alu_addsub_acc #(.LEN(L)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_a(i_a), .i_b(i_b),
      .i_mode(i_mode), .i_sat(i_sat), .i_clr_flags(i_clr_flags), .o_valid(o_valid),
      .i_ready(i_ready), .o_sum(o_sum), .o_carry(o_carry), .o_ovf_sticky(o_ovf_sticky), .o_acc(o_acc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int wrapv(input int r);
      int w;
      w = r & ((1 << L) - 1);
      return (w > MAXV) ? w - (1 << L) : w;
   endfunction

   task automatic chk_state(input string tag);
      chk({tag, ".valid"}, int'(o_valid), m_valid);
      chk({tag, ".sum"}, int'(o_sum), m_sum);
      chk({tag, ".carry"}, int'(o_carry), m_carry);
      chk({tag, ".sticky"}, int'(o_ovf_sticky), m_sticky);
      chk({tag, ".acc"}, int'(o_acc), m_acc);
   endtask

   // one clock cycle: drive, check ready, advance model, check registered outputs
   task automatic cyc(input logic v, input logic [1:0] md, input int a, input int b,
                      input logic s, input logic clr, input logic rdy);
      int r, res, ov;
      bit acc;
      i_valid = v; i_mode = md; i_a = a[L-1:0]; i_b = b[L-1:0];
      i_sat = s; i_clr_flags = clr; i_ready = rdy;
      #1;
      chk("ready", int'(o_ready), int'(m_valid == 0 || rdy));
      acc = v && (m_valid == 0 || rdy);
      a = wrapv(a); b = wrapv(b);
      r = (md == 2'd0) ? a + b : (md == 2'd1) ? a - b : (md == 2'd2) ? m_acc + a : a;
      ov = (md != 2'd3) && (r > MAXV || r < MINV);
      res = (md == 2'd3) ? a : (ov && s) ? ((r > 0) ? MAXV : MINV) : wrapv(r);
      if (acc) begin
         m_sum = res; m_carry = ov; m_valid = 1;
         if (md[1]) m_acc = res;
      end else if (rdy) m_valid = 0;
      m_sticky = (acc && ov) ? 1 : clr ? 0 : m_sticky;
      @(posedge clk);
      #1;
      chk_state("model");
   endtask

   initial begin
      rst = 1'b1; i_valid = 0; i_mode = 0; i_a = 0; i_b = 0;
      i_sat = 0; i_clr_flags = 0; i_ready = 1;
      #11;
      chk_state("reset");
      chk("reset.ready", int'(o_ready), 1);
      rst = 1'b0;
      #1;
      // wrap overflow then no overflow, sticky holds
      cyc(1, 2'd0, 7, 1, 0, 0, 1);
      chk("tp_wrap_sum", int'(o_sum), -8);
      chk("tp_wrap_carry", int'(o_carry), 1);
      cyc(1, 2'd0, -3, 2, 0, 0, 1);
      chk("tp_wrap2_sum", int'(o_sum), -1);
      chk("tp_sticky_hold", int'(o_ovf_sticky), 1);
      // saturation
      cyc(1, 2'd0, 7, 1, 1, 0, 1);
      chk("tp_sat_add", int'(o_sum), 7);
      cyc(1, 2'd1, -8, 1, 1, 0, 1);
      chk("tp_sat_sub", int'(o_sum), -8);
      chk("tp_sat_sub_c", int'(o_carry), 1);
      cyc(1, 2'd1, 3, -4, 1, 0, 1);
      chk("tp_sub_edge", int'(o_sum), 7);
      chk("tp_sub_edge_c", int'(o_carry), 0);
      // accumulate saturating, then wrapping
      cyc(1, 2'd3, 5, 0, 1, 0, 1);
      cyc(1, 2'd2, 2, 5, 1, 0, 1);
      chk("tp_acc1", int'(o_sum), 7);
      cyc(1, 2'd2, 1, 0, 1, 0, 1);
      chk("tp_acc2", int'(o_sum), 7);
      chk("tp_acc2_c", int'(o_carry), 1);
      cyc(1, 2'd2, 3, 0, 1, 0, 1);
      chk("tp_acc3", int'(o_acc), 7);
      cyc(1, 2'd3, 5, 0, 0, 0, 1);
      cyc(1, 2'd2, 2, 0, 0, 0, 1);
      cyc(1, 2'd2, 1, 0, 0, 0, 1);
      chk("tp_accw2", int'(o_sum), -8);
      cyc(1, 2'd2, 3, 0, 0, 0, 1);
      chk("tp_accw3", int'(o_sum), -5);
      // backpressure
      cyc(1, 2'd0, 2, 3, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 2'd0, 1, 1, 0, 0, 0);
         chk("tp_bp_hold", int'(o_sum), 5);
      end
      cyc(1, 2'd0, 1, 1, 0, 0, 1);
      chk("tp_bp_resume", int'(o_sum), 2);
      // clear vs set collision, then clear alone
      cyc(1, 2'd0, 7, 1, 0, 1, 1);
      chk("tp_clr_set", int'(o_ovf_sticky), 1);
      cyc(0, 2'd0, 0, 0, 0, 1, 1);
      chk("tp_clr", int'(o_ovf_sticky), 0);
      // async reset while stalled with acc=6
      cyc(1, 2'd3, 6, 0, 0, 0, 1);
      cyc(1, 2'd0, 7, 7, 0, 0, 1);
      cyc(0, 2'd0, 0, 0, 0, 0, 0);
      i_valid = 0;
      #2 rst = 1'b1;
      #1;
      m_valid = 0; m_sum = 0; m_carry = 0; m_sticky = 0; m_acc = 0;
      chk_state("async_rst");
      chk("async_rst.ready", int'(o_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      cyc(1, 2'd2, 2, 0, 0, 0, 1);
      chk("tp_post_rst_acc", int'(o_sum), 2);
      // random traffic
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 3) != 0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
